// File: rtl/fetch_unit.sv
// Instruction fetch stage for the unpipelined WISC-SP13 core: owns the PC,
// runs the imem request/ack handshake, and holds one instruction until retire.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        halted,
    output logic        misalign,
    output logic [15:0] retired_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] pc_r;
    logic [15:0] instr_r;
    logic [15:0] retired_cnt_r;
    logic        halted_r;
    logic        misalign_r;
    logic        retire_s;
    logic        bad_target_s;
    logic        stop_s;

    // Retire qualification and next-state selection.
    always_comb begin
        retire_s     = 1'b0;
        bad_target_s = 1'b0;
        stop_s       = 1'b0;
        state_nxt_s  = state_r;
        retire_s     = (state_r == ST_HOLD) && instr_ready;
        bad_target_s = redirect && redirect_pc[0];
        stop_s       = halt || bad_target_s;
        case (state_r)
            ST_BOOT: state_nxt_s = ST_REQ;
            ST_REQ: begin
                if (imem_ack) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (!instr_ready) begin
                    state_nxt_s = ST_HOLD;
                end else if (stop_s) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_HALT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // PC, fetched word, sticky flags and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            instr_r       <= NOP_INSTR;
            retired_cnt_r <= 16'd0;
            halted_r      <= 1'b0;
            misalign_r    <= 1'b0;
        end else begin
            if ((state_r == ST_REQ) && imem_ack) begin
                instr_r <= imem_rdata;
            end
            if (retire_s) begin
                retired_cnt_r <= retired_cnt_r + 16'd1;
                if (stop_s) begin
                    // pc stays on the HALT / misaligned jump for debug visibility
                    halted_r   <= 1'b1;
                    misalign_r <= misalign_r | (!halt && bad_target_s);
                end else if (redirect) begin
                    pc_r <= redirect_pc;
                end else begin
                    pc_r <= pc_r + 16'd2;
                end
            end
        end
    end

    assign imem_req    = (state_r == ST_REQ);
    assign imem_addr   = pc_r;
    assign instr_valid = (state_r == ST_HOLD);
    assign instr       = (state_r == ST_HOLD) ? instr_r : NOP_INSTR;
    assign pc          = pc_r;
    assign pc_plus2    = pc_r + 16'd2;
    assign halted      = halted_r;
    assign misalign    = misalign_r;
    assign retired_cnt = retired_cnt_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: the driver models memory and the
// datapath and queues expected fetches; a negedge monitor checks them.
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_ack = 1'b0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        halted;
    logic        misalign;
    logic [15:0] retired_cnt;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .pc_plus2(pc_plus2),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .halted(halted), .misalign(misalign), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] addr; logic [15:0] cnt; } req_t;
    typedef struct { logic [15:0] pc; logic [15:0] word; } fetch_t;

    req_t   exp_req_q[$];
    fetch_t exp_fetch_q[$];

    int checks = 0;
    int passes = 0;

    logic [15:0] model_pc;
    logic [15:0] model_cnt;
    logic        model_mis;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return 16'h4000 + a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compares each new request and each newly presented instruction.
    logic   req_prev = 1'b0;
    logic   val_prev = 1'b0;
    logic [15:0] cur_addr = 16'h0000;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_req_q.delete();
            exp_fetch_q.delete();
            req_prev = 1'b0;
            val_prev = 1'b0;
        end else begin
            if (!instr_valid) chk("nop_when_invalid", {16'h0, instr}, {16'h0, NOP_INSTR});
            if (imem_req && !req_prev) begin
                if (exp_req_q.size() == 0) begin
                    chk("unexpected_req", {16'h0, imem_addr}, 32'hFFFF_FFFF);
                end else begin
                    req_t r;
                    r = exp_req_q.pop_front();
                    cur_addr = r.addr;
                    chk("req_addr", {16'h0, imem_addr}, {16'h0, r.addr});
                    chk("req_retired_cnt", {16'h0, retired_cnt}, {16'h0, r.cnt});
                end
            end else if (imem_req) begin
                chk("req_addr_stable", {16'h0, imem_addr}, {16'h0, cur_addr});
            end
            if (instr_valid && !val_prev) begin
                if (exp_fetch_q.size() == 0) begin
                    chk("unexpected_valid", {16'h0, instr}, 32'hFFFF_FFFF);
                end else begin
                    fetch_t f;
                    f = exp_fetch_q.pop_front();
                    chk("instr", {16'h0, instr}, {16'h0, f.word});
                    chk("pc", {16'h0, pc}, {16'h0, f.pc});
                    chk("pc_plus2", {16'h0, pc_plus2}, {16'h0, f.pc + 16'd2});
                end
            end
            req_prev = imem_req;
            val_prev = instr_valid;
        end
    end

    task automatic noise(input logic with_ack);
        redirect    = 1'($urandom % 2);
        halt        = 1'($urandom % 2);
        redirect_pc = 16'($urandom);
        imem_rdata  = 16'($urandom);
        imem_ack    = with_ack ? 1'($urandom % 2) : 1'b0;
        instr_ready = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        instr_ready = 1'b0; imem_ack = 1'b0; redirect = 1'b0; halt = 1'b0;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'd0);
        chk("rst_valid", {31'h0, instr_valid}, 32'd0);
        chk("rst_pc", {16'h0, pc}, {16'h0, RESET_PC});
        chk("rst_flags", {30'h0, halted, misalign}, 32'd0);
        chk("rst_cnt", {16'h0, retired_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        model_pc = RESET_PC; model_cnt = 16'd0; model_mis = 1'b0;
        exp_req_q.push_back('{addr: RESET_PC, cnt: 16'd0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 16'hDEAD;
        chk("boot_no_req", {31'h0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        chk("req_after_boot", {31'h0, imem_req}, 32'd1);
        chk("boot_ack_ignored", {31'h0, instr_valid}, 32'd0);
    endtask

    task automatic do_instr(input int dly, input int hld, input logic rd,
                            input logic [15:0] tgt, input logic hlt);
        int n = 0;
        while (!imem_req && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!imem_req) begin
            chk("req_timeout", 32'd0, 32'd1);
            return;
        end
        for (int i = 0; i < dly; i++) begin
            noise(1'b0);
            @(posedge clk); #1;
        end
        redirect = 1'b0; halt = 1'b0;
        exp_fetch_q.push_back('{pc: model_pc, word: mem_fn(model_pc)});
        imem_ack = 1'b1;
        imem_rdata = mem_fn(imem_addr);
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("valid_after_ack", {31'h0, instr_valid}, 32'd1);
        for (int i = 0; i < hld; i++) begin
            noise(1'b1);
            @(posedge clk); #1;
        end
        imem_ack = 1'b0;
        instr_ready = 1'b1; redirect = rd; redirect_pc = tgt; halt = hlt;
        model_cnt = model_cnt + 16'd1;
        if (hlt) begin
        end else if (rd && tgt[0]) begin
            model_mis = 1'b1;
        end else begin
            model_pc = rd ? tgt : model_pc + 16'd2;
            exp_req_q.push_back('{addr: model_pc, cnt: model_cnt});
        end
        @(posedge clk); #1;
        instr_ready = 1'b0; redirect = 1'b0; halt = 1'b0;
    endtask

    task automatic halt_phase();
        for (int i = 0; i < 20; i++) begin
            imem_ack = 1'($urandom % 2);
            imem_rdata = 16'($urandom);
            @(posedge clk); #1;
            chk("halt_quiet", {30'h0, imem_req, instr_valid}, 32'd0);
        end
        imem_ack = 1'b0;
        chk("halted", {31'h0, halted}, 32'd1);
        chk("misalign", {31'h0, misalign}, {31'h0, model_mis});
        chk("halt_pc", {16'h0, pc}, {16'h0, model_pc});
        chk("halt_cnt", {16'h0, retired_cnt}, {16'h0, model_cnt});
    endtask

    initial begin
        #2;
        reset_dut();
        do_instr(0, 0, 1'b0, 16'h0, 1'b0);
        do_instr(5, 0, 1'b0, 16'h0, 1'b0);
        do_instr(0, 0, 1'b0, 16'h0, 1'b0);
        chk("cnt_after_3", {16'h0, retired_cnt}, 32'd3);
        do_instr(1, 2, 1'b0, 16'h0, 1'b0);
        // Now requesting 0008: reset in the middle of the request.
        @(posedge clk); #1;
        chk("mid_req_addr", {16'h0, imem_addr}, 32'h0008);
        reset_dut();
        do_instr(2, 1, 1'b1, 16'h0100, 1'b0);
        do_instr(0, 0, 1'b1, 16'hFFFE, 1'b0);
        do_instr(1, 0, 1'b0, 16'h0, 1'b0);
        do_instr(0, 1, 1'b0, 16'h0, 1'b0);
        do_instr(0, 0, 1'b0, 16'h0, 1'b0);
        do_instr(3, 0, 1'b0, 16'h0, 1'b0);
        chk("pre_halt_pc", {16'h0, pc}, 32'h0006);
        do_instr(0, 0, 1'b0, 16'h0, 1'b1);
        halt_phase();
        reset_dut();
        for (int i = 0; i < 40; i++) begin
            logic        rd;
            logic [15:0] tgt;
            rd  = ($urandom % 10) < 3;
            tgt = (($urandom % 8) == 0) ? 16'hFFFE : 16'($urandom) & 16'hFFFE;
            do_instr($urandom_range(0, 3), $urandom_range(0, 2), rd, tgt, 1'b0);
        end
        do_instr(1, 1, 1'b1, 16'h0011, 1'b0);
        halt_phase();
        chk("req_queue_drained", exp_req_q.size(), 32'd0);
        chk("fetch_queue_drained", exp_fetch_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1);
    end

endmodule
